// File: rtl/memi_multifetch_pkg.sv
// Shared definitions for the multi-fetch instruction memory.
// Contains the init FSM state type, the RV32I encodings used to build the
// boot words, and init_val(), which gives the word written to each address
// while the array is being cleared.
// Build option: define MEMI_PRELOAD_EN to seed addresses 0..2 with a boot program.
package memi_multifetch_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } init_state_t;

  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [2:0] FUNCT3_JALR = 3'b000;
  localparam logic [2:0] FUNCT3_ADDI = 3'b000;
  localparam logic [4:0] REG_X0      = 5'd0;
  localparam logic [4:0] REG_RA      = 5'd1;

  // JALR x0, 0(x1)  -> 32'h0000_8067
  localparam logic [31:0] BOOT_JALR_RA = {12'd0, REG_RA, FUNCT3_JALR, REG_X0, OP_JALR};
  // ADDI x0, x0, 0  -> 32'h0000_0013
  localparam logic [31:0] BOOT_NOP     = {12'd0, REG_X0, FUNCT3_ADDI, REG_X0, OP_IMM};

`ifdef MEMI_PRELOAD_EN
  localparam bit PRELOAD_EN = 1'b1;
`else
  localparam bit PRELOAD_EN = 1'b0;
`endif

  // Word written to address idx during the clear sweep.
  function automatic logic [31:0] init_val(input logic [31:0] idx);
    logic [31:0] w;
    w = 32'd0;
    if (PRELOAD_EN) begin
      case (idx)
        32'd0:        w = BOOT_JALR_RA;
        32'd1, 32'd2: w = BOOT_NOP;
        default:      w = 32'd0;
      endcase
    end
    return w;
  endfunction

endpackage

// File: rtl/memi_init_ctrl.sv
// Init sequencer: sweeps clr_cnt over every word after reset, then parks in READY.
// Latency: DEPTH cycles from rst release to init_done (registered).
// Backpressure: none; the sweep always advances one word per cycle.
// Ports: clk, rst (sync, active-high); init_we/init_addr drive the array
// write port during the sweep; init_done is high once the sweep has finished.
module memi_init_ctrl
  import memi_multifetch_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_we,
  output logic [ADDR_W-1:0] init_addr,
  output logic              init_done
);

  init_state_t       state;
  logic [ADDR_W-1:0] clr_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      clr_cnt   <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
            state     <= ST_READY;
            init_done <= 1'b1;
          end
        end
        default: begin
          state <= ST_READY;
        end
      endcase
    end
  end

  // Suppressed while rst is high so the array is left alone on the reset
  // cycle even when reset lands in the middle of a sweep.
  assign init_we   = (state == ST_INIT) && !rst;
  assign init_addr = clr_cnt;

endmodule

// File: rtl/memi_multifetch.sv
// Instruction memory returning FETCH_W consecutive words per accepted request.
// Latency: 1 cycle from request accept to resp_valid (registered read).
// Backpressure: req_ready drops while a response is held with resp_ready low.
// Ports: clk, rst (sync, active-high); init_done; req_valid/req_ready/req_addr;
// resp_valid/resp_ready/resp_addr/resp_data (lane k at [k*INST_LEN +: INST_LEN]);
// wr_en/wr_addr/wr_data program-load port (ignored until init_done).
// Build option: MEMI_PRELOAD_EN seeds a boot program during init.
module memi_multifetch
  import memi_multifetch_pkg::*;
#(
  parameter int INST_LEN = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = $clog2(DEPTH),
  parameter int FETCH_W  = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        init_done,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ADDR_W-1:0]           req_addr,
  output logic                        resp_valid,
  input  logic                        resp_ready,
  output logic [ADDR_W-1:0]           resp_addr,
  output logic [FETCH_W*INST_LEN-1:0] resp_data,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [INST_LEN-1:0]         wr_data
);

  logic [INST_LEN-1:0]         mem [DEPTH];
  logic                        init_we;
  logic [ADDR_W-1:0]           init_addr;
  logic [FETCH_W*INST_LEN-1:0] rd_lanes;
  logic                        req_fire;

  memi_init_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_init_ctrl (
    .clk       (clk),
    .rst       (rst),
    .init_we   (init_we),
    .init_addr (init_addr),
    .init_done (init_done)
  );

  // Init sweep owns the write port; loader writes only land once READY.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_addr] <= INST_LEN'(init_val(32'(init_addr)));
    end else if (wr_en && init_done && !rst) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Lane addresses wrap naturally through ADDR_W truncation. Reads sample the
  // array before this edge's write, so a same-cycle write returns the old word.
  for (genvar k = 0; k < FETCH_W; k++) begin : g_lane
    assign rd_lanes[k*INST_LEN +: INST_LEN] = mem[ADDR_W'(req_addr + ADDR_W'(k))];
  end

  assign req_ready = init_done && !rst && (!resp_valid || resp_ready);
  assign req_fire  = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_addr  <= '0;
      resp_data  <= '0;
    end else if (req_fire) begin
      resp_valid <= 1'b1;
      resp_addr  <= req_addr;
      resp_data  <= rd_lanes;
    end else if (resp_ready) begin
      // Drained with nothing new: data/addr keep their last value.
      resp_valid <= 1'b0;
    end
  end

endmodule
